mem_stage: RTL and testbench

//  Memory-access stage directly downstream of the execute ALU. Consumes op, alu_o,

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/mem_stage_if.sv | 42 ++++
 rtl/dmem_sram.sv | 26 ++
 rtl/mem_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, memory-stage FSM states and
// default data-memory geometry.
package cpu_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int MEM_AW    = 8;

  // ALU opcodes occupy 000000..000101
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLT = 6'b000101;
  localparam logic [5:0] OP_SW  = 6'b010000;
  localparam logic [5:0] OP_LW  = 6'b010001;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_JMP = 6'b100001;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  function automatic logic is_alu_op(input logic [5:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute -> memory-stage bus plus the stage's write-back / redirect outputs.
// Optional: MEM_ERR_EN adds the mem_err pulse.
//
// Handshake: an instruction transfers on a rising clk edge where
// ex_valid && ex_ready are both high. The master holds ex_op/ex_alu_o/
// ex_addr_o/ex_ife/ex_rd stable while ex_valid is high and ex_ready is low;
// ex_ready never depends combinationally on ex_valid. The wb_* and
// redirect_* outputs carry no back-pressure: they are one-cycle results.
interface mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_op;
  logic [31:0] ex_alu_o;
  logic [31:0] ex_addr_o;
  logic        ex_ife;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef MEM_ERR_EN
  logic        mem_err;
`endif

  modport master (
`ifdef MEM_ERR_EN
    input  mem_err,
`endif
    output ex_valid, ex_op, ex_alu_o, ex_addr_o, ex_ife, ex_rd,
    input  ex_ready, wb_valid, wb_we, wb_rd, wb_data, redirect_valid, redirect_pc
  );

  modport slave (
`ifdef MEM_ERR_EN
    output mem_err,
`endif
    input  ex_valid, ex_op, ex_alu_o, ex_addr_o, ex_ife, ex_rd,
    output ex_ready, wb_valid, wb_we, wb_rd, wb_data, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/dmem_sram.sv
// Single-port data memory: synchronous write, synchronous (1-cycle) read.
// Contents are not reset.
module dmem_sram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Array write and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: executes SW/LW against dmem_sram, turns BEQ/JMP into
// a fetch redirect and registers the write-back result.
// Optional: MEM_ERR_EN flags misaligned / out-of-range SW/LW addresses.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = MEM_AW
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_err_q, ld_err_d;
  logic        mem_err_q, mem_err_d;

  logic        accept;
  logic        is_mem;
  logic        addr_err;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign accept = bus.ex_valid && bus.ex_ready;
  assign is_mem = (bus.ex_op == OP_SW) || (bus.ex_op == OP_LW);

`ifdef MEM_ERR_EN
  // Misaligned, or beyond the last word of the memory
  assign addr_err = (bus.ex_addr_o[1:0] != 2'b00) || (bus.ex_addr_o[31:AW+2] != '0);
  assign bus.mem_err = mem_err_q;
`else
  // Without checking, the address simply wraps modulo DEPTH words
  assign addr_err = 1'b0;
`endif

  assign ram_we = accept && (bus.ex_op == OP_SW) && !addr_err;
  assign ram_re = accept && (bus.ex_op == OP_LW);

  dmem_sram #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (bus.ex_addr_o[AW+1:2]),
    .wdata (bus.ex_alu_o),
    .rdata (ram_rdata)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a load holds the stage for exactly one extra cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (bus.ex_op == OP_LW)) state_d = LOAD;
      LOAD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: back-pressure while the load word is being collected
  always_comb begin
    bus.ex_ready = (state_q == IDLE);
    dbg_state    = state_q;
  end

  // Next write-back / redirect values; everything is a one-cycle result
  always_comb begin
    wb_valid_d       = 1'b0;
    wb_we_d          = 1'b0;
    wb_rd_d          = '0;
    wb_data_d        = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    ld_rd_d          = ld_rd_q;
    ld_err_d         = ld_err_q;
    mem_err_d        = accept && is_mem && addr_err;
    if (state_q == LOAD) begin
      wb_valid_d = 1'b1;
      wb_we_d    = !ld_err_q;
      wb_rd_d    = ld_rd_q;
      wb_data_d  = ld_err_q ? 32'h0 : ram_rdata;
    end else if (accept) begin
      if (is_alu_op(bus.ex_op)) begin
        wb_valid_d = 1'b1;
        wb_we_d    = 1'b1;
        wb_rd_d    = bus.ex_rd;
        wb_data_d  = bus.ex_alu_o;
      end else begin
        case (bus.ex_op)
          OP_LW: begin
            ld_rd_d  = bus.ex_rd;
            ld_err_d = addr_err;
          end
          OP_BEQ: begin
            wb_valid_d       = 1'b1;
            wb_rd_d          = bus.ex_rd;
            redirect_valid_d = bus.ex_ife;
            redirect_pc_d    = bus.ex_addr_o;
          end
          OP_JMP: begin
            wb_valid_d       = 1'b1;
            wb_rd_d          = bus.ex_rd;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = bus.ex_addr_o;
          end
          default: begin
            // SW and unknown opcodes: slot is valid but writes nothing
            wb_valid_d = 1'b1;
            wb_rd_d    = bus.ex_rd;
          end
        endcase
      end
    end
  end

  // Output and load-context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q       <= 1'b0;
      wb_we_q          <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      ld_rd_q          <= '0;
      ld_err_q         <= 1'b0;
      mem_err_q        <= 1'b0;
    end else begin
      wb_valid_q       <= wb_valid_d;
      wb_we_q          <= wb_we_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      ld_rd_q          <= ld_rd_d;
      ld_err_q         <= ld_err_d;
      mem_err_q        <= mem_err_d;
    end
  end

  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_we          = wb_we_q;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

`ifndef MEM_ERR_EN
  // mem_err_q has no consumer without the error port
  logic unused_mem_err;
  assign unused_mem_err = mem_err_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (MEM_ERR_EN selects error tests).
module tb_mem_stage;
  import cpu_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     errors;
  int     checks;
  logic [31:0] exp_q[$];

  mem_stage_if bus();

  mem_stage u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one instruction at negedge, sample #1 after the accept edge
  task automatic drive_one(input logic [5:0] op, input logic [31:0] alu,
                           input logic [31:0] addr, input logic ife,
                           input logic [4:0] rd);
    @(negedge clk);
    bus.ex_op     = op;
    bus.ex_alu_o  = alu;
    bus.ex_addr_o = addr;
    bus.ex_ife    = ife;
    bus.ex_rd     = rd;
    bus.ex_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.ex_valid  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_op = '0; bus.ex_alu_o = '0;
    bus.ex_addr_o = '0; bus.ex_ife = 1'b0; bus.ex_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %0b want 0", bus.wb_valid); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL rst_wb_we: got %0b want 0", bus.wb_we); end
    checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wb_rd: got %0d want 0", bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data: got %h want 0", bus.wb_data); end
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_valid: got %0b want 0", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc: got %h want 0", bus.redirect_pc); end
    checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL rst_ex_ready: got %0b want 1", bus.ex_ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
`ifdef MEM_ERR_EN
    checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL rst_mem_err: got %0b want 0", bus.mem_err); end
`endif
  endtask

  task automatic test_alu();
    drive_one(OP_ADD, 32'h0000_0007, 32'h0, 1'b0, 5'd3);
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid: got %0b want 1", bus.wb_valid); end
    checks++; if (bus.wb_we !== 1'b1) begin errors++; $display("FAIL add_wb_we: got %0b want 1", bus.wb_we); end
    checks++; if (bus.wb_rd !== 5'd3) begin errors++; $display("FAIL add_wb_rd: got %0d want 3", bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'h7) begin errors++; $display("FAIL add_wb_data: got %h want 7", bus.wb_data); end
    drive_one(OP_SLT, 32'hA5A5_0001, 32'h0, 1'b0, 5'd31);
    checks++; if (bus.wb_data !== 32'hA5A5_0001) begin errors++; $display("FAIL slt_wb_data: got %h want a5a50001", bus.wb_data); end
    checks++; if (bus.wb_rd !== 5'd31) begin errors++; $display("FAIL slt_wb_rd: got %0d want 31", bus.wb_rd); end
    idle_cycle();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL idle_wb_valid: got %0b want 0", bus.wb_valid); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL idle_wb_we: got %0b want 0", bus.wb_we); end
    drive_one(6'b111111, 32'h1234, 32'h0, 1'b0, 5'd9);
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL other_wb_valid: got %0b want 1", bus.wb_valid); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL other_wb_we: got %0b want 0", bus.wb_we); end
  endtask

  task automatic test_sw_lw();
    drive_one(OP_SW, 32'hDEAD_BEEF, 32'h10, 1'b0, 5'd0);
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL sw_wb_we: got %0b want 0", bus.wb_we); end
    drive_one(OP_LW, 32'h0, 32'h10, 1'b0, 5'd5);
    checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL lw_ex_ready_busy: got %0b want 0", bus.ex_ready); end
    checks++; if (dbg_state !== LOAD) begin errors++; $display("FAIL lw_state: got %0d want LOAD", dbg_state); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL lw_early_wb_valid: got %0b want 0", bus.wb_valid); end
    idle_cycle();
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL lw_wb_valid: got %0b want 1", bus.wb_valid); end
    checks++; if (bus.wb_we !== 1'b1) begin errors++; $display("FAIL lw_wb_we: got %0b want 1", bus.wb_we); end
    checks++; if (bus.wb_rd !== 5'd5) begin errors++; $display("FAIL lw_wb_rd: got %0d want 5", bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wb_data: got %h want deadbeef", bus.wb_data); end
    checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL lw_ex_ready_back: got %0b want 1", bus.ex_ready); end
    idle_cycle();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL lw_after_wb_valid: got %0b want 0", bus.wb_valid); end
  endtask

  task automatic test_branch();
    drive_one(OP_BEQ, 32'h0, 32'h40, 1'b1, 5'd0);
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_taken_valid: got %0b want 1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h40) begin errors++; $display("FAIL beq_taken_pc: got %h want 40", bus.redirect_pc); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL beq_wb_we: got %0b want 0", bus.wb_we); end
    idle_cycle();
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL redirect_pulse: got %0b want 0", bus.redirect_valid); end
    drive_one(OP_BEQ, 32'h0, 32'h44, 1'b0, 5'd0);
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got %0b want 0", bus.redirect_valid); end
    drive_one(OP_JMP, 32'h0, 32'h80, 1'b0, 5'd0);
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL jmp_valid: got %0b want 1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h80) begin errors++; $display("FAIL jmp_pc: got %h want 80", bus.redirect_pc); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL jmp_wb_we: got %0b want 0", bus.wb_we); end
  endtask

`ifndef MEM_ERR_EN
  task automatic test_wrap();
    // 256*4+8 wraps to word 2, the same word as byte address 0x8
    drive_one(OP_SW, 32'h1234_5678, 32'h0000_0408, 1'b0, 5'd0);
    drive_one(OP_LW, 32'h0, 32'h8, 1'b0, 5'd12);
    idle_cycle();
    checks++; if (bus.wb_data !== 32'h1234_5678) begin errors++; $display("FAIL wrap_lw_data: got %h want 12345678", bus.wb_data); end
    checks++; if (bus.wb_we !== 1'b1) begin errors++; $display("FAIL wrap_lw_we: got %0b want 1", bus.wb_we); end
    // low address bits are ignored: 0x0B reads word 2 too
    drive_one(OP_LW, 32'h0, 32'h0000_000B, 1'b0, 5'd13);
    idle_cycle();
    checks++; if (bus.wb_data !== 32'h1234_5678) begin errors++; $display("FAIL wrap_lowbits_data: got %h want 12345678", bus.wb_data); end
  endtask
`else
  task automatic test_mem_err();
    drive_one(OP_SW, 32'hCAFE_0001, 32'h20, 1'b0, 5'd0);
    checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL err_good_sw: got %0b want 0", bus.mem_err); end
    drive_one(OP_SW, 32'hBAD0_BAD0, 32'h23, 1'b0, 5'd0);
    checks++; if (bus.mem_err !== 1'b1) begin errors++; $display("FAIL err_sw_flag: got %0b want 1", bus.mem_err); end
    idle_cycle();
    checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %0b want 0", bus.mem_err); end
    drive_one(OP_LW, 32'h0, 32'h20, 1'b0, 5'd8);
    idle_cycle();
    checks++; if (bus.wb_data !== 32'hCAFE_0001) begin errors++; $display("FAIL err_mem_unchanged: got %h want cafe0001", bus.wb_data); end
    drive_one(OP_LW, 32'h0, 32'h13, 1'b0, 5'd9);
    checks++; if (bus.mem_err !== 1'b1) begin errors++; $display("FAIL err_lw_flag: got %0b want 1", bus.mem_err); end
    checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL err_lw_busy: got %0b want 0", bus.ex_ready); end
    idle_cycle();
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL err_lw_valid: got %0b want 1", bus.wb_valid); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL err_lw_we: got %0b want 0", bus.wb_we); end
    checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL err_lw_data: got %h want 0", bus.wb_data); end
    drive_one(OP_SW, 32'h5555_AAAA, 32'h400, 1'b0, 5'd0);
    checks++; if (bus.mem_err !== 1'b1) begin errors++; $display("FAIL err_range_flag: got %0b want 1", bus.mem_err); end
    drive_one(OP_LW, 32'h0, 32'h0, 1'b0, 5'd1);
    idle_cycle();
    checks++; if (bus.wb_data === 32'h5555_AAAA) begin errors++; $display("FAIL err_range_write: got %h want not 5555aaaa", bus.wb_data); end
  endtask
`endif

  task automatic test_reset_in_load();
    drive_one(OP_LW, 32'h0, 32'h10, 1'b0, 5'd7);
    checks++; if (dbg_state !== LOAD) begin errors++; $display("FAIL rl_state_load: got %0d want LOAD", dbg_state); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL rl_ex_ready: got %0b want 1", bus.ex_ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rl_state_idle: got %0d want IDLE", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rl_no_wb_valid: got %0b want 0", bus.wb_valid); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL rl_no_wb_we: got %0b want 0", bus.wb_we); end
    checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL rl_wb_data: got %h want 0", bus.wb_data); end
  endtask

  // Back-to-back stream with an ADD held stalled behind a load
  task automatic test_back_to_back();
    logic [5:0]  ops   [4];
    logic [31:0] alus  [4];
    int          cycles;
    logic        rdy;
    logic        done;
    ops[0] = OP_ADD; alus[0] = 32'd1;
    ops[1] = OP_SUB; alus[1] = 32'd2;
    ops[2] = OP_LW;  alus[2] = 32'd0;
    ops[3] = OP_XOR; alus[3] = 32'd9;
    exp_q = {};
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'd9);
    cycles = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ex_op = ops[i]; bus.ex_alu_o = alus[i]; bus.ex_addr_o = 32'h10;
      bus.ex_ife = 1'b0; bus.ex_rd = 5'(i + 1); bus.ex_valid = 1'b1;
      done = 1'b0;
      for (int w = 0; w < 8 && !done; w++) begin
        rdy = bus.ex_ready;
        @(posedge clk);
        #1;
        cycles++;
        if (bus.wb_valid && bus.wb_we) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra_wb: got %h want none", bus.wb_data); end
          else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.wb_data !== e) begin errors++; $display("FAIL b2b_wb_data: got %h want %h", bus.wb_data, e); end
          end
        end
        if (rdy) done = 1'b1;
        else @(negedge clk);
      end
      if (!done) begin checks++; errors++; $display("FAIL b2b_timeout: got no accept want accept in 8 cycles"); end
      bus.ex_valid = 1'b0;
    end
    idle_cycle();
    cycles++;
    if (bus.wb_valid && bus.wb_we) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra_wb: got %h want none", bus.wb_data); end
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.wb_data !== e) begin errors++; $display("FAIL b2b_wb_data: got %h want %h", bus.wb_data, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d left want 0", exp_q.size()); end
    checks++; if (cycles != 6) begin errors++; $display("FAIL b2b_cycles: got %0d want 6", cycles); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_alu();
    test_sw_lw();
    test_branch();
`ifndef MEM_ERR_EN
    test_wrap();
`else
    test_mem_err();
`endif
    test_back_to_back();
    test_reset_in_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
